// File: rtl/res50_frame_sink.sv
`default_nettype none
// ============================================================================
//  Module   : res50_frame_sink
//  Purpose  : Receive side of the res50 frame scan. Tracks vsync/hsync/data
//             run strobes, rebuilds row/col/chn of each beat, writes beats to
//             the frame buffer port and flags protocol / length faults.
//  Revision : 1.0  initial release
// ============================================================================
module res50_frame_sink #(
    parameter int W_SIZE       = 8,
    parameter int W_FRAME_SIZE = 2*W_SIZE+3,
    parameter int W_DATA       = 16,
    parameter int W_ADDR       = W_FRAME_SIZE+W_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SIZE-1:0]       q_height,
    input  logic [W_SIZE-1:0]       q_channel,
    input  logic [W_SIZE-1:0]       q_step_x,
    input  logic [W_SIZE-1:0]       q_step_y,
    input  logic [W_FRAME_SIZE-1:0] q_frame_size,
    input  logic                    q_clear,
    input  logic                    i_vsync_run,
    input  logic                    i_hsync_run,
    input  logic                    i_data_run,
    input  logic [W_DATA-1:0]       i_data,
    output logic                    o_wr_en,
    output logic [W_ADDR-1:0]       o_wr_addr,
    output logic [W_DATA-1:0]       o_wr_data,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic [W_SIZE-1:0]       o_chn,
    output logic [W_FRAME_SIZE-1:0] o_data_count,
    output logic                    o_line_done,
    output logic                    o_frame_done,
    output logic                    o_busy,
    output logic                    o_err_proto,
    output logic                    o_err_len
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VSYNC = 2'd1,
        ST_HSYNC = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    localparam logic [W_SIZE-1:0] C_ONE = W_SIZE'(1);

    state_t                  state_q, state_d;
    logic [W_SIZE-1:0]       erow_q, erow_d;
    logic [W_SIZE-1:0]       ecol_q, ecol_d;
    logic [W_SIZE-1:0]       echn_q, echn_d;
    logic [W_ADDR-1:0]       addr_q, addr_d;
    logic [W_FRAME_SIZE-1:0] cnt_q, cnt_d;

    logic                    wr_en_q, wr_en_d;
    logic [W_ADDR-1:0]       wr_addr_q, wr_addr_d;
    logic [W_DATA-1:0]       wr_data_q, wr_data_d;
    logic [W_SIZE-1:0]       row_q, row_d;
    logic [W_SIZE-1:0]       col_q, col_d;
    logic [W_SIZE-1:0]       chn_q, chn_d;
    logic                    line_done_q, line_done_d;
    logic                    frame_done_q, frame_done_d;
    logic                    busy_q, busy_d;
    logic                    err_proto_q, err_proto_d;
    logic                    err_len_q, err_len_d;

    logic [W_SIZE-1:0]       col_last, row_last, chn_last;
    logic                    multi_run, ev, eh, ed;
    logic                    is_chn_last, is_col_last, is_eol, is_eof;
    logic                    accept, clear_pos, proto_fault, len_fault;

    assign col_last = q_width - q_step_x;
    assign row_last = q_height - q_step_y;
    assign chn_last = q_channel - C_ONE;

    // Simultaneous strobes are a fault; the highest-priority one is still honoured.
    assign multi_run = (i_vsync_run & i_hsync_run) | (i_vsync_run & i_data_run)
                     | (i_hsync_run & i_data_run);
    assign ev = i_vsync_run;
    assign eh = i_hsync_run & ~i_vsync_run;
    assign ed = i_data_run & ~i_vsync_run & ~i_hsync_run;

    assign is_chn_last = (echn_q == chn_last);
    assign is_col_last = (ecol_q == col_last);
    assign is_eol      = is_chn_last & is_col_last;
    assign is_eof      = is_eol & (erow_q == row_last);

    always_comb begin
        state_d      = state_q;
        erow_d       = erow_q;
        ecol_d       = ecol_q;
        echn_d       = echn_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        row_d        = row_q;
        col_d        = col_q;
        chn_d        = chn_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        accept       = 1'b0;
        clear_pos    = 1'b0;
        proto_fault  = multi_run;
        len_fault    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ev) begin
                    state_d   = ST_VSYNC;
                    clear_pos = 1'b1;
                end else if (ed) begin
                    proto_fault = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (ev) begin
                    clear_pos = 1'b1;
                end else if (eh) begin
                    state_d = ST_HSYNC;
                end else if (ed) begin
                    proto_fault = 1'b1;
                end
            end
            ST_HSYNC: begin
                if (ev) begin
                    proto_fault = 1'b1;
                    state_d     = ST_VSYNC;
                    clear_pos   = 1'b1;
                end else if (ed) begin
                    accept = 1'b1;
                end
            end
            ST_DATA: begin
                if (ev) begin
                    proto_fault = 1'b1;
                    state_d     = ST_VSYNC;
                    clear_pos   = 1'b1;
                end else if (ed) begin
                    accept = 1'b1;
                end else begin
                    // Line cut short: keep position so the next line resumes here.
                    proto_fault = 1'b1;
                    state_d     = ST_HSYNC;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = addr_q;
            wr_data_d    = i_data;
            row_d        = erow_q;
            col_d        = ecol_q;
            chn_d        = echn_q;
            line_done_d  = is_eol;
            frame_done_d = is_eof;
            addr_d       = addr_q + W_ADDR'(1);
            if (is_chn_last) begin
                cnt_d  = cnt_q + W_FRAME_SIZE'(1);
                echn_d = '0;
                if (is_col_last) begin
                    ecol_d = '0;
                    erow_d = erow_q + q_step_y;
                end else begin
                    ecol_d = ecol_q + q_step_x;
                end
            end else begin
                echn_d = echn_q + C_ONE;
            end
            if (is_eof) begin
                state_d   = ST_IDLE;
                len_fault = (cnt_d != q_frame_size);
            end else if (is_eol) begin
                state_d = ST_HSYNC;
            end else begin
                state_d = ST_DATA;
            end
        end

        if (clear_pos) begin
            erow_d = '0;
            ecol_d = '0;
            echn_d = '0;
            addr_d = '0;
            cnt_d  = '0;
        end

        // A fault in the same cycle as q_clear keeps the flag set.
        err_proto_d = proto_fault ? 1'b1 : (q_clear ? 1'b0 : err_proto_q);
        err_len_d   = len_fault   ? 1'b1 : (q_clear ? 1'b0 : err_len_q);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            erow_q       <= '0;
            ecol_q       <= '0;
            echn_q       <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            chn_q        <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_proto_q  <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            erow_q       <= erow_d;
            ecol_q       <= ecol_d;
            echn_q       <= echn_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            row_q        <= row_d;
            col_q        <= col_d;
            chn_q        <= chn_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_proto_q  <= err_proto_d;
            err_len_q    <= err_len_d;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_row        = row_q;
    assign o_col        = col_q;
    assign o_chn        = chn_q;
    assign o_data_count = cnt_q;
    assign o_line_done  = line_done_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = busy_q;
    assign o_err_proto  = err_proto_q;
    assign o_err_len    = err_len_q;

endmodule
`default_nettype wire

// File: tb/tb_res50_frame_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_res50_frame_sink
//  Purpose  : Directed scoreboard bench for res50_frame_sink.
//  Revision : 1.0  initial release
// ============================================================================
module tb_res50_frame_sink;

    localparam int W_SIZE       = 8;
    localparam int W_FRAME_SIZE = 2*W_SIZE+3;
    localparam int W_DATA       = 16;
    localparam int W_ADDR       = W_FRAME_SIZE+W_SIZE;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [W_SIZE-1:0]       q_width, q_height, q_channel, q_step_x, q_step_y;
    logic [W_FRAME_SIZE-1:0] q_frame_size;
    logic                    q_clear;
    logic                    i_vsync_run, i_hsync_run, i_data_run;
    logic [W_DATA-1:0]       i_data;
    logic                    o_wr_en;
    logic [W_ADDR-1:0]       o_wr_addr;
    logic [W_DATA-1:0]       o_wr_data;
    logic [W_SIZE-1:0]       o_row, o_col, o_chn;
    logic [W_FRAME_SIZE-1:0] o_data_count;
    logic                    o_line_done, o_frame_done, o_busy, o_err_proto, o_err_len;

    res50_frame_sink #(
        .W_SIZE(W_SIZE), .W_FRAME_SIZE(W_FRAME_SIZE), .W_DATA(W_DATA), .W_ADDR(W_ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
        .q_step_x(q_step_x), .q_step_y(q_step_y), .q_frame_size(q_frame_size),
        .q_clear(q_clear),
        .i_vsync_run(i_vsync_run), .i_hsync_run(i_hsync_run), .i_data_run(i_data_run),
        .i_data(i_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_data_count(o_data_count),
        .o_line_done(o_line_done), .o_frame_done(o_frame_done), .o_busy(o_busy),
        .o_err_proto(o_err_proto), .o_err_len(o_err_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic [W_SIZE-1:0] row;
        logic [W_SIZE-1:0] col;
        logic [W_SIZE-1:0] chn;
        logic [W_DATA-1:0] data;
        logic              eol;
        logic              eof;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int geo_w, geo_h, geo_c, geo_sx, geo_sy;
    int m_row, m_col, m_chn, m_addr, m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr",    64'(o_wr_addr),    64'(e.addr));
                check("row",        64'(o_row),        64'(e.row));
                check("col",        64'(o_col),        64'(e.col));
                check("chn",        64'(o_chn),        64'(e.chn));
                check("wr_data",    64'(o_wr_data),    64'(e.data));
                check("line_done",  64'(o_line_done),  64'(e.eol));
                check("frame_done", 64'(o_frame_done), 64'(e.eof));
            end
        end else begin
            check("done_without_write", 64'({o_line_done, o_frame_done}), 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic d, input int n);
        i_vsync_run = v;
        i_hsync_run = h;
        i_data_run  = d;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input int w, input int h, input int c, input int sx, input int sy, input int fs);
        geo_w = w; geo_h = h; geo_c = c; geo_sx = sx; geo_sy = sy;
        q_width  = W_SIZE'(w);  q_height = W_SIZE'(h); q_channel = W_SIZE'(c);
        q_step_x = W_SIZE'(sx); q_step_y = W_SIZE'(sy);
        q_frame_size = W_FRAME_SIZE'(fs);
    endtask

    function automatic bit model_eol();
        return (m_col == geo_w - geo_sx) && (m_chn == geo_c - 1);
    endfunction

    // One accepted beat: record the expectation, drive it, then move the model on.
    task automatic beat();
        exp_t e;
        logic [W_DATA-1:0] dv;
        dv     = W_DATA'($urandom);
        e.addr = W_ADDR'(m_addr);
        e.row  = W_SIZE'(m_row);
        e.col  = W_SIZE'(m_col);
        e.chn  = W_SIZE'(m_chn);
        e.data = dv;
        e.eol  = model_eol();
        e.eof  = model_eol() && (m_row == geo_h - geo_sy);
        sb.push_back(e);
        i_data = dv;
        drive(1'b0, 1'b0, 1'b1, 1);
        m_addr++;
        if (m_chn == geo_c - 1) m_cnt++;
        m_chn++;
        if (m_chn == geo_c) begin
            m_chn = 0;
            m_col += geo_sx;
            if (m_col > geo_w - geo_sx) begin
                m_col = 0;
                m_row += geo_sy;
            end
        end
    endtask

    task automatic finish_line();
        bit last;
        last = 1'b0;
        while (!last) begin
            last = model_eol();
            beat();
        end
    endtask

    task automatic start_frame();
        m_row = 0; m_col = 0; m_chn = 0; m_addr = 0; m_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 2);
    endtask

    task automatic full_line();
        drive(1'b0, 1'b1, 1'b0, 2);
        finish_line();
    endtask

    task automatic remaining_lines();
        while (m_row <= geo_h - geo_sy) full_line();
        drive(1'b0, 1'b0, 1'b0, 1);
    endtask

    initial begin
        rst = 1'b1; q_clear = 1'b0; i_data = '0;
        i_vsync_run = 1'b0; i_hsync_run = 1'b0; i_data_run = 1'b0;
        cfg(4, 2, 3, 1, 1, 8);
        tick(); tick();
        check("reset_wr_en",  64'(o_wr_en), 64'd0);
        check("reset_addr",   64'(o_wr_addr), 64'd0);
        check("reset_count",  64'(o_data_count), 64'd0);
        check("reset_busy",   64'(o_busy), 64'd0);
        check("reset_errors", 64'({o_err_proto, o_err_len}), 64'd0);
        rst = 1'b0;
        tick();

        // Basic 4x2x3 frame
        start_frame();
        check("busy_after_vsync", 64'(o_busy), 64'd1);
        remaining_lines();
        check("t1_count",  64'(o_data_count), 64'd8);
        check("t1_errors", 64'({o_err_proto, o_err_len}), 64'd0);
        check("t1_busy",   64'(o_busy), 64'd0);

        // Data strobe in idle: dropped, flagged
        drive(1'b0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b0, 1);
        check("idle_data_proto", 64'(o_err_proto), 64'd1);
        q_clear = 1'b1; tick(); q_clear = 1'b0;
        check("clear_proto", 64'(o_err_proto), 64'd0);
        // hsync+data together is a fault even in idle
        drive(1'b0, 1'b1, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b0, 1);
        check("multi_run_proto", 64'(o_err_proto), 64'd1);
        q_clear = 1'b1; tick(); q_clear = 1'b0;

        // Strided geometry
        cfg(8, 4, 1, 2, 2, 8);
        start_frame();
        remaining_lines();
        check("t2_count",  64'(o_data_count), 64'd8);
        check("t2_errors", 64'({o_err_proto, o_err_len}), 64'd0);

        // Line cut short after 10 beats, resumes at addr 10 without hsync
        cfg(4, 2, 3, 1, 1, 8);
        start_frame();
        drive(1'b0, 1'b1, 1'b0, 2);
        for (int i = 0; i < 10; i++) beat();
        drive(1'b0, 1'b0, 1'b0, 1);
        check("drop_proto", 64'(o_err_proto), 64'd1);
        check("drop_busy",  64'(o_busy), 64'd1);
        check("drop_model_addr", 64'(m_addr), 64'd10);
        finish_line();
        remaining_lines();
        check("t3_count",   64'(o_data_count), 64'd8);
        check("t3_err_len", 64'(o_err_len), 64'd0);
        q_clear = 1'b1; tick(); q_clear = 1'b0;

        // Frame length mismatch
        cfg(4, 2, 3, 1, 1, 9);
        start_frame();
        remaining_lines();
        check("t4_err_len", 64'(o_err_len), 64'd1);
        check("t4_count",   64'(o_data_count), 64'd8);
        q_clear = 1'b1; tick(); q_clear = 1'b0;
        check("t4_cleared", 64'(o_err_len), 64'd0);
        cfg(4, 2, 3, 1, 1, 8);

        // Vsync during line 1 resyncs; fresh frame follows
        start_frame();
        full_line();
        drive(1'b0, 1'b1, 1'b0, 2);
        for (int i = 0; i < 5; i++) beat();
        start_frame();
        check("resync_proto", 64'(o_err_proto), 64'd1);
        remaining_lines();
        check("t5_count",   64'(o_data_count), 64'd8);
        check("t5_err_len", 64'(o_err_len), 64'd0);
        q_clear = 1'b1; tick(); q_clear = 1'b0;

        // Reset in the middle of a frame
        start_frame();
        drive(1'b0, 1'b1, 1'b0, 2);
        for (int i = 0; i < 5; i++) beat();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1);
        check("rst_wr_en", 64'(o_wr_en), 64'd0);
        check("rst_busy",  64'(o_busy), 64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1);
        start_frame();
        remaining_lines();
        check("t6_count",  64'(o_data_count), 64'd8);
        check("t6_errors", 64'({o_err_proto, o_err_len}), 64'd0);

        drive(1'b0, 1'b0, 1'b0, 3);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
